// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised register file. It has NUM_RD combinational read
//            ports and two write lanes, A and B. B is the younger lane and
//            wins when both lanes write the same entry. Entry 0 can be
//            hardwired to zero, and same-cycle write data can be forwarded
//            to the read ports. A sequential clear engine flushes the file
//            one entry per cycle without using reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic                     write_en_a,
    input  logic [ADDR_W-1:0]        write_addr_a,
    input  logic [DATA_W-1:0]        write_data_a,
    input  logic                     write_en_b,
    input  logic [ADDR_W-1:0]        write_addr_b,
    input  logic [DATA_W-1:0]        write_data_b,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     wr_conflict
);

    localparam int                c_depth    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_idx = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [DATA_W-1:0] r_mem [c_depth];
    logic              r_wr_conflict;
    logic              w_clearing;
    logic              w_we_a;
    logic              w_we_b;
    logic              w_conflict;

    assign w_clearing = (r_state == S_CLEAR);

    // A write is effective only outside a clear and, when entry 0 is
    // hardwired, only to a nonzero address. The same qualified enables
    // gate storage, bypass and conflict detection, so all three agree.
    assign w_we_a = write_en_a && !w_clearing &&
                    !((ZERO_REG != 0) && (write_addr_a == '0));
    assign w_we_b = write_en_b && !w_clearing &&
                    !((ZERO_REG != 0) && (write_addr_b == '0));

    assign w_conflict = w_we_a && w_we_b && (write_addr_a == write_addr_b);

    assign busy        = w_clearing;
    assign wr_conflict = r_wr_conflict;

    // Clear engine state register and sweep index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Clear engine next state: sweep every entry once, then return to idle
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_idx_nxt = r_idx + ADDR_W'(1);
                if (r_idx == c_last_idx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Storage array: lane B is assigned last so it wins on a shared address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clearing) begin
            r_mem[r_idx] <= '0;
        end else begin
            if (w_we_a) begin
                r_mem[write_addr_a] <= write_data_a;
            end
            if (w_we_b) begin
                r_mem[write_addr_b] <= write_data_b;
            end
        end
    end

    // One-cycle pulse flagging a same-address write on both lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_conflict <= 1'b0;
        end else begin
            r_wr_conflict <= w_conflict;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = read_addr[g*ADDR_W +: ADDR_W];

        // Read mux. Priority is zero entry, then bypass B, then bypass A,
        // then the array.
        always_comb begin
            w_rd = r_mem[w_ra];
            if (BYPASS != 0) begin
                if (w_we_b && (write_addr_b == w_ra)) begin
                    w_rd = write_data_b;
                end else if (w_we_a && (write_addr_a == w_ra)) begin
                    w_rd = write_data_a;
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign read_data[g*DATA_W +: DATA_W] = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp. One instance uses the
//            default bypassing configuration. A second instance has four
//            read ports and no bypass. Expected read values are queued when
//            stimulus is driven and popped when the outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        clr;
    logic        busy;
    logic        wrc;

    logic [19:0]  ra2;
    logic [127:0] rd2;
    logic         we2;
    logic [4:0]   wa2;
    logic [31:0]  wd2;
    logic         busy2;
    logic         wrc2;

    int          checks;
    int          errors;
    int          busy_cnt;
    logic [31:0] e;
    logic [31:0] exp_q[$];
    logic [31:0] mdl [32];

    regfile_mp dut (
        .clk          (clk),
        .rst          (rst),
        .read_addr    (ra),
        .read_data    (rd),
        .write_en_a   (we_a),
        .write_addr_a (wa_a),
        .write_data_a (wd_a),
        .write_en_b   (we_b),
        .write_addr_b (wa_b),
        .write_data_b (wd_b),
        .clear_req    (clr),
        .busy         (busy),
        .wr_conflict  (wrc)
    );

    regfile_mp #(.NUM_RD(4), .BYPASS(0)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .read_addr    (ra2),
        .read_data    (rd2),
        .write_en_a   (we2),
        .write_addr_a (wa2),
        .write_data_a (wd2),
        .write_en_b   (1'b0),
        .write_addr_b (5'd0),
        .write_data_b (32'd0),
        .clear_req    (1'b0),
        .busy         (busy2),
        .wr_conflict  (wrc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0;
        we_b = 1'b0;
        clr  = 1'b0;
        we2  = 1'b0;
    endtask

    task automatic mdl_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        if (en && (a != 5'd0)) mdl[a] = d;
    endtask

    task automatic mdl_zero();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        wa_a = '0; wd_a = '0; wa_b = '0; wd_b = '0; wa2 = '0; wd2 = '0;
        ra  = {5'd3, 5'd7};
        ra2 = {4{5'd12}};
        mdl_zero();
        #100;
        exp_q.push_back(mdl[7]);
        exp_q.push_back(mdl[3]);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL reset_rd port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        checks++;
        if (rd2[31:0] !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd2 got %h want 0", rd2[31:0]);
        end
        checks++;
        if (busy !== 1'b0 || busy2 !== 1'b0 || wrc !== 1'b0 || wrc2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b/%b wrc=%b/%b want 0", busy, busy2, wrc, wrc2);
        end
        #100;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'd327;
        cyc();
        mdl_wr(we_a, wa_a, wd_a);
        wa_a = 5'd3; wd_a = 32'd36827;
        cyc();
        mdl_wr(we_a, wa_a, wd_a);
        idle();
        ra = {5'd3, 5'd7};
        exp_q.push_back(32'd327);
        exp_q.push_back(32'd36827);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL basic_rd port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        cyc();
    endtask

    task automatic test_conflict();
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h11;
        we_b = 1'b1; wa_b = 5'd5; wd_b = 32'h22;
        ra = {5'd5, 5'd5};
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h22);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL conflict_bypass port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        checks++;
        if (wrc !== 1'b0) begin
            errors++;
            $display("FAIL conflict_early got %b want 0", wrc);
        end
        cyc();
        mdl_wr(we_a, wa_a, wd_a);
        mdl_wr(we_b, wa_b, wd_b);
        idle();
        exp_q.push_back(mdl[5]);
        exp_q.push_back(mdl[5]);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL conflict_store port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        checks++;
        if (wrc !== 1'b1) begin
            errors++;
            $display("FAIL conflict_pulse got %b want 1", wrc);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (wrc !== 1'b0) begin
            errors++;
            $display("FAIL conflict_width got %b want 0", wrc);
        end
        cyc();
    endtask

    task automatic test_bypass();
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h55;
        we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h77;
        ra = {5'd7, 5'd9};
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h77);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL bypass_lanes port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        cyc();
        mdl_wr(we_a, wa_a, wd_a);
        mdl_wr(we_b, wa_b, wd_b);
        idle();
        @(negedge clk);
        checks++;
        if (wrc !== 1'b0) begin
            errors++;
            $display("FAIL bypass_noconflict got %b want 0", wrc);
        end
        cyc();
    endtask

    task automatic test_zero();
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hDEAD;
        we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hDEAD;
        ra = {5'd0, 5'd0};
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL zero_same port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        cyc();
        mdl_wr(we_a, wa_a, wd_a);
        mdl_wr(we_b, wa_b, wd_b);
        idle();
        exp_q.push_back(mdl[0]);
        exp_q.push_back(mdl[0]);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL zero_after port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        checks++;
        if (wrc !== 1'b0) begin
            errors++;
            $display("FAIL zero_conflict got %b want 0", wrc);
        end
        cyc();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 16; i++) begin
            we_a = 1'b1; wa_a = 5'(2*i);   wd_a = 32'(2*i + 1);
            we_b = 1'b1; wa_b = 5'(2*i+1); wd_b = 32'(2*i + 2);
            cyc();
            mdl_wr(we_a, wa_a, wd_a);
            mdl_wr(we_b, wa_b, wd_b);
        end
        idle();
        ra = {5'd31, 5'd1};
        exp_q.push_back(mdl[1]);
        exp_q.push_back(mdl[31]);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL fill_rd port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        cyc();
        clr = 1'b1;
        cyc();
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            idle();
            if (n == 5) begin
                we_a = 1'b1; wa_a = 5'd30; wd_a = 32'd99;
                ra = {5'd31, 5'd30};
                exp_q.push_back(mdl[30]);
                exp_q.push_back(mdl[31]);
            end
            if (n == 10) clr = 1'b1;
            if (n == 32) begin
                we_a = 1'b1; wa_a = 5'd30; wd_a = 32'd99;
                we_b = 1'b1; wa_b = 5'd30; wd_b = 32'd99;
            end
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (n == 5) begin
                for (int p = 0; p < 2; p++) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (rd[p*32 +: 32] !== e) begin
                        errors++;
                        $display("FAIL clear_midread port%0d got %h want %h", p, rd[p*32 +: 32], e);
                    end
                end
            end
            if (n == 33) begin
                checks++;
                if (wrc !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_end got wrc=%b busy=%b want 0 0", wrc, busy);
                end
            end
            cyc();
        end
        idle();
        mdl_zero();
        checks++;
        if (busy_cnt != 32) begin
            errors++;
            $display("FAIL clear_busy_cycles got %0d want 32", busy_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            ra = {5'(2*i+1), 5'(2*i)};
            exp_q.push_back(mdl[2*i]);
            exp_q.push_back(mdl[2*i+1]);
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = exp_q.pop_front();
                checks++;
                if (rd[p*32 +: 32] !== e) begin
                    errors++;
                    $display("FAIL clear_rd entry%0d got %h want %h", 2*i+p, rd[p*32 +: 32], e);
                end
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid_clear();
        we_a = 1'b1; wa_a = 5'd20; wd_a = 32'h88;
        cyc();
        mdl_wr(we_a, wa_a, wd_a);
        idle();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (9) cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstclr_busy got %b want 0", busy);
        end
        mdl_zero();
        ra = {5'd20, 5'd20};
        exp_q.push_back(mdl[20]);
        exp_q.push_back(mdl[20]);
        #1;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL rstclr_rd port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        cyc();
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h1234;
        cyc();
        mdl_wr(we_a, wa_a, wd_a);
        idle();
        ra = {5'd20, 5'd9};
        exp_q.push_back(mdl[9]);
        exp_q.push_back(mdl[20]);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL rstclr_write port%0d got %h want %h", p, rd[p*32 +: 32], e);
            end
        end
        repeat (30) cyc();
        exp_q.push_back(32'h1234);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rd[31:0] !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstclr_hold got %h busy=%b want %h busy=0", rd[31:0], busy, e);
        end
        cyc();
    endtask

    task automatic test_no_bypass();
        we2 = 1'b1; wa2 = 5'd12; wd2 = 32'h1111;
        cyc();
        wd2 = 32'hABCD;
        ra2 = {4{5'd12}};
        for (int p = 0; p < 4; p++) exp_q.push_back(32'h1111);
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd2[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL nobyp_old port%0d got %h want %h", p, rd2[p*32 +: 32], e);
            end
        end
        cyc();
        idle();
        for (int p = 0; p < 4; p++) exp_q.push_back(32'hABCD);
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd2[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL nobyp_new port%0d got %h want %h", p, rd2[p*32 +: 32], e);
            end
        end
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_conflict();
        test_bypass();
        test_zero();
        test_clear();
        test_reset_mid_clear();
        test_no_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
